pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_perf_cnt.sv | 24 ++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for pipe_ctrl: FSM state encodings, redirect codes,
// flush bit positions and write-enable bit positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] REDIR_NONE = 2'b00;
  localparam logic [1:0] REDIR_BR   = 2'b01;
  localparam logic [1:0] REDIR_EXC  = 2'b10;
  localparam logic [1:0] REDIR_ERTN = 2'b11;

  // Bubble-insert bits; bit 2 (ex_mm1) is only ever raised as part of a full flush.
  localparam int unsigned FL_IF_ID   = 0;
  localparam int unsigned FL_ID_EX   = 1;
  localparam int unsigned FL_MM1_MM2 = 3;
  localparam int unsigned FL_MM2_WB  = 4;

  localparam int unsigned W_PC      = 0;
  localparam int unsigned W_IF_ID   = 1;
  localparam int unsigned W_ID_EX   = 2;
  localparam int unsigned W_EX_MM1  = 3;
  localparam int unsigned W_MM1_MM2 = 4;
  localparam int unsigned W_MM2_WB  = 5;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counters for pipe_ctrl (stall cycles, flush events).
// Only instantiated when PIPE_PERF_EN is defined.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc && (flush_events != '1))
        flush_events <= flush_events + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: BOOT/RUN/FLUSH FSM driving stage write
// enables, bubble inserts and redirect select. Optional macro: PIPE_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_stall_req,
  input  logic       id_load_use,
  input  logic       ex_busy,
  input  logic       mm1_busy,
  input  logic       ex_br_taken,
  input  logic       wb_exc,
  input  logic       wb_ertn,
  input  logic       wb_refetch,
  output logic       wen_pc,
  output logic       wen_if_id,
  output logic       wen_id_ex,
  output logic       wen_ex_mm1,
  output logic       wen_mm1_mm2,
  output logic       wen_mm2_wb,
  output logic [4:0] flush,
  output logic [1:0] redir_sel,
  output logic [1:0] ctrl_state
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       wen;
  logic             wb_ev;

  assign wb_ev = wb_exc | wb_ertn | wb_refetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wen       = '1;
    flush     = '0;
    redir_sel = REDIR_NONE;
    case (state)
      ST_BOOT: begin
        wen[W_PC] = 1'b0;
        flush     = '1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (wb_ev) begin
          flush     = '1;
          redir_sel = wb_exc ? REDIR_EXC : REDIR_ERTN;
          cnt_nxt   = CNT_W'(DRAIN_CYC);
          state_nxt = ST_FLUSH;
        end else if (mm1_busy) begin
          wen[W_MM1_MM2:W_PC] = '0;
          flush[FL_MM2_WB]    = 1'b1;
        end else if (ex_busy) begin
          wen[W_EX_MM1:W_PC]  = '0;
          flush[FL_MM1_MM2]   = 1'b1;
        end else if (id_load_use) begin
          wen[W_IF_ID:W_PC]   = '0;
          flush[FL_ID_EX]     = 1'b1;
          // A resolved branch still redirects fetch while ID is held.
          if (ex_br_taken) begin
            wen[W_PC]        = 1'b1;
            flush[FL_IF_ID]  = 1'b1;
            redir_sel        = REDIR_BR;
          end
        end else if (ex_br_taken) begin
          flush[FL_ID_EX:FL_IF_ID] = 2'b11;
          redir_sel                = REDIR_BR;
        end else if (if_stall_req) begin
          wen[W_PC]       = 1'b0;
          flush[FL_IF_ID] = 1'b1;
        end
      end
      ST_FLUSH: begin
        wen[W_PC] = 1'b0;
        flush     = '1;
        if (!mm1_busy) begin
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign wen_pc      = wen[W_PC];
  assign wen_if_id   = wen[W_IF_ID];
  assign wen_id_ex   = wen[W_ID_EX];
  assign wen_ex_mm1  = wen[W_EX_MM1];
  assign wen_mm1_mm2 = wen[W_MM1_MM2];
  assign wen_mm2_wb  = wen[W_MM2_WB];
  assign ctrl_state  = state;

`ifdef PIPE_PERF_EN
  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    ((state == ST_RUN) && !wen[W_PC]),
    .flush_inc    ((state == ST_RUN) && (state_nxt == ST_FLUSH)),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Covers PIPE_PERF_EN when defined.
module tb_pipe_ctrl;

  localparam logic [7:0] IF   = 8'h01;
  localparam logic [7:0] LU   = 8'h02;
  localparam logic [7:0] EXB  = 8'h04;
  localparam logic [7:0] MM1  = 8'h08;
  localparam logic [7:0] BR   = 8'h10;
  localparam logic [7:0] EXC  = 8'h20;
  localparam logic [7:0] ERTN = 8'h40;
  localparam logic [7:0] REF  = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_stall_req = 1'b0, id_load_use = 1'b0, ex_busy = 1'b0, mm1_busy = 1'b0;
  logic ex_br_taken = 1'b0, wb_exc = 1'b0, wb_ertn = 1'b0, wb_refetch = 1'b0;
  logic wen_pc, wen_if_id, wen_id_ex, wen_ex_mm1, wen_mm1_mm2, wen_mm2_wb;
  logic [4:0] flush;
  logic [1:0] redir_sel, ctrl_state;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  pipe_ctrl #(.DRAIN_CYC(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_stall_req (if_stall_req),
    .id_load_use  (id_load_use),
    .ex_busy      (ex_busy),
    .mm1_busy     (mm1_busy),
    .ex_br_taken  (ex_br_taken),
    .wb_exc       (wb_exc),
    .wb_ertn      (wb_ertn),
    .wb_refetch   (wb_refetch),
    .wen_pc       (wen_pc),
    .wen_if_id    (wen_if_id),
    .wen_id_ex    (wen_id_ex),
    .wen_ex_mm1   (wen_ex_mm1),
    .wen_mm1_mm2  (wen_mm1_mm2),
    .wen_mm2_wb   (wen_mm2_wb),
    .flush        (flush),
    .redir_sel    (redir_sel),
    .ctrl_state   (ctrl_state)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } item_t;

  item_t q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  bit          stim_done = 1'b0;

  // Expected vector: {state, redir, flush, wen{mm2_wb,mm1_mm2,ex_mm1,id_ex,if_id,pc}}
  function automatic logic [14:0] e(logic [1:0] st, logic [1:0] rd,
                                    logic [4:0] fl, logic [5:0] wn);
    return {st, rd, fl, wn};
  endfunction

  localparam logic [14:0] X_BOOT   = {2'b00, 2'b00, 5'b11111, 6'b111110};
  localparam logic [14:0] X_IDLE   = {2'b01, 2'b00, 5'b00000, 6'b111111};
  localparam logic [14:0] X_FLUSH  = {2'b10, 2'b00, 5'b11111, 6'b111110};

  task automatic step(input logic rst, input logic [7:0] v,
                      input logic [14:0] exp, input string name);
    item_t it;
    @(posedge clk);
    #1;
    rst_n        = rst;
    if_stall_req = v[0];
    id_load_use  = v[1];
    ex_busy      = v[2];
    mm1_busy     = v[3];
    ex_br_taken  = v[4];
    wb_exc       = v[5];
    wb_ertn      = v[6];
    wb_refetch   = v[7];
    it.name = name;
    it.exp  = exp;
    q.push_back(it);
  endtask

  initial begin : monitor
    item_t       it;
    logic [14:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        got = {ctrl_state, redir_sel, flush, wen_mm2_wb, wen_mm1_mm2,
               wen_ex_mm1, wen_id_ex, wen_if_id, wen_pc};
        checks++;
        if (got !== it.exp)
          $display("FAIL %s: got st=%b rd=%b fl=%b wen=%b, want st=%b rd=%b fl=%b wen=%b",
                   it.name, got[14:13], got[12:11], got[10:6], got[5:0],
                   it.exp[14:13], it.exp[12:11], it.exp[10:6], it.exp[5:0]);
        else
          passed++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset and boot sequence
    step(1'b0, 8'h00, X_BOOT, "reset_hold");
    step(1'b0, 8'h00, X_BOOT, "reset_hold2");
    step(1'b1, 8'h00, X_BOOT, "boot_cycle");
    step(1'b1, 8'h00, X_IDLE, "run_idle");

    // mm1_busy dominates ex_busy for three cycles, then ex_busy shows
    repeat (3) step(1'b1, MM1 | EXB, e(2'b01, 2'b00, 5'b10000, 6'b100000), "mm1_over_ex");
    step(1'b1, EXB, e(2'b01, 2'b00, 5'b01000, 6'b110000), "ex_busy");
    step(1'b1, EXB | BR, e(2'b01, 2'b00, 5'b01000, 6'b110000), "br_ignored_ex_busy");
    step(1'b1, MM1 | BR | LU, e(2'b01, 2'b00, 5'b10000, 6'b100000), "br_ignored_mm1");
    step(1'b1, LU, e(2'b01, 2'b00, 5'b00010, 6'b111100), "load_use");
    step(1'b1, LU | BR | IF, e(2'b01, 2'b01, 5'b00011, 6'b111101), "load_use_br");
    step(1'b1, BR, e(2'b01, 2'b01, 5'b00011, 6'b111111), "branch");
    step(1'b1, 8'h00, X_IDLE, "branch_one_cycle");
    step(1'b1, IF, e(2'b01, 2'b00, 5'b00001, 6'b111110), "if_stall");

    // exc+ertn with everything else raised; mm1_busy holds first drain cycle
    step(1'b1, EXC | ERTN | MM1 | BR | EXB, e(2'b01, 2'b10, 5'b11111, 6'b111111), "wb_exc_prio");
    step(1'b1, MM1, X_FLUSH, "flush_hold");
    step(1'b1, REF | BR | EXC, X_FLUSH, "flush_ignore_events");
    step(1'b1, 8'h00, X_FLUSH, "flush_last");
    step(1'b1, 8'h00, X_IDLE, "flush_done");

    step(1'b1, ERTN | REF, e(2'b01, 2'b11, 5'b11111, 6'b111111), "wb_ertn");
    step(1'b1, 8'h00, X_FLUSH, "ertn_flush1");
    step(1'b1, 8'h00, X_FLUSH, "ertn_flush2");
    step(1'b1, REF | IF, e(2'b01, 2'b11, 5'b11111, 6'b111111), "wb_refetch");
    step(1'b1, 8'h00, X_FLUSH, "ref_flush1");
    step(1'b1, 8'h00, X_FLUSH, "ref_flush2");
    step(1'b1, 8'h00, X_IDLE, "ref_done");

    // Reset mid-drain takes effect without a clock edge and abandons the drain
    step(1'b1, EXC, e(2'b01, 2'b10, 5'b11111, 6'b111111), "pre_reset_exc");
    step(1'b1, 8'h00, X_FLUSH, "pre_reset_flush");
    step(1'b0, 8'h00, X_BOOT, "async_reset");
    step(1'b1, 8'h00, X_BOOT, "reset_release");
    step(1'b1, 8'h00, X_IDLE, "after_reset_run");

`ifdef PIPE_PERF_EN
    step(1'b0, 8'h00, X_BOOT, "perf_reset");
    step(1'b1, 8'h00, X_BOOT, "perf_boot");
    repeat (5) step(1'b1, IF, e(2'b01, 2'b00, 5'b00001, 6'b111110), "perf_stall");
    step(1'b1, EXC, e(2'b01, 2'b10, 5'b11111, 6'b111111), "perf_exc");
    step(1'b1, 8'h00, X_FLUSH, "perf_flush1");
    step(1'b1, 8'h00, X_FLUSH, "perf_flush2");
    step(1'b1, 8'h00, X_IDLE, "perf_run");
    #2;
    checks++;
    if (stall_cycles !== 32'd5)
      $display("FAIL stall_cycles: got %0d, want 5", stall_cycles);
    else
      passed++;
    checks++;
    if (flush_events !== 16'd1)
      $display("FAIL flush_events: got %0d, want 1", flush_events);
    else
      passed++;
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
